pe_acc_requant: RTL
===================

Name: pe_acc_requant

Overview:
Downstream stage of the 3-tap dot-product PE. It consumes the PE's registered signed partial sums, accumulates a group of them (e.g. the 3 row results of a 3x3 convolution, or K/3 chunks of a longer dot product), and requantizes the total back to 8-bit activation width.
- Requantization: optional ReLU, rounding arithmetic right shift, then saturation.
- Valid/ready handshake on both sides, so it can sit between the PE array and an output buffer.

Parameters:
IW, 18, signed input width (PE output width, A+B+2 with A=B=8)
ACC_W, 24, signed accumulator width, ACC_W >= IW
OW, 8, signed output width
SH_W, 5, width of cfg_shift
CNT_W, 8, width of the beat counter

Ports:
i_clk  input  1  clock
i_resetn  input  1  reset
in_valid  input  1  in_data beat valid
in_ready  output  1  block can accept a beat
in_data  input  IW  signed partial sum from PE
in_last  input  1  final beat of the current group
cfg_shift  input  SH_W  right-shift amount, 0..ACC_W-1
cfg_relu  input  1  1 = clamp negative totals to 0 before shifting
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_data  output  OW  signed requantized result
out_sat  output  1  accumulator or output saturation occurred in this group
out_cnt  output  CNT_W  number of beats in this group

Behaviour:
- Reset: i_resetn is asynchronous and active-low; i_clk is the clock. While reset is asserted:
  - state=ACC, acc=0, cnt=0, sat flag=0.
  - out_valid=0, out_data=0, out_sat=0, out_cnt=0.
- in_ready is 1 in ACC and 0 in OUT. A beat transfers when in_valid and in_ready are both 1.
- States:
  - ACC: each accepted beat adds sign-extended in_data to acc.
    - Saturating add: on overflow, acc clamps to max/min of ACC_W and the sat flag sets.
    - cnt increments and saturates at all-ones.
    - An accepted beat with in_last=1 computes final = sat_add(acc, in_data). It registers the result into out_data/out_sat/out_cnt (cnt includes this beat), clears acc/cnt/sat, and moves to OUT.
    - Latency: out_valid is high on the cycle after in_last is accepted.
  - OUT: out_valid=1. out_data, out_sat and out_cnt are held stable until out_valid and out_ready are both 1, then the block returns to ACC. No bypass: at least one bubble cycle follows each result.
- Requant, applied to final using cfg_shift/cfg_relu sampled on the in_last beat:
  1. If cfg_relu=1 and final<0, final=0.
  2. If cfg_shift>0: r = (final + 2^(cfg_shift-1)) >>> cfg_shift, i.e. round half up, arithmetic shift, computed in ACC_W+1 bits. Otherwise r = final.
  3. Saturate r to [-2^(OW-1), 2^(OW-1)-1]. If clamping occurs, out_sat=1.
- Boundary cases:
  - A group of a single beat with in_last=1 is legal.
  - in_valid=0 cycles inside a group are allowed; acc holds.
  - in_data during OUT is ignored, since in_ready=0.
  - Reset mid-group discards the partial acc. Reset in OUT drops the pending result.
  - cfg_shift >= ACC_W is illegal; the result is undefined, and the bench must not drive it.

Decomposition:
- Shared package:
  - Default widths IW/ACC_W/OW.
  - State encoding constants ST_ACC/ST_OUT.
  - Saturation limit constants as functions of width.
- One natural sub-module: requant_sat (combinational ReLU, round-shift and saturate, parameterized by ACC_W/OW/SH_W). Top level holds the FSM, accumulator and counter.

Test Plan:
1. Beats 100, 200, -50 (last on third), shift=1, relu=1 -> out_data=125, out_cnt=3, out_sat=0, out_valid 1 cycle after last.
2. Single beat 1000 last, shift=2 -> (1002>>2)=250 clamps to out_data=127, out_sat=1.
3. Single beat -300 last: relu=1, shift=0 -> out_data=0, sat=0; then relu=0 -> out_data=-128, sat=1.
4. Backpressure:
   - Stimulus: out_ready=0 for 5 cycles after result, with in_valid=1 held throughout.
   - Response: out_valid and out_data stable, in_ready=0, no beats accepted; out_ready=1 -> ACC next cycle, new group starts clean from acc=0.
5. Accumulator saturation:
   - Stimulus: ACC_W=20, five beats of 131071, shift=0.
   - Response: acc clamps at 524287, out_data=127, out_sat=1, out_cnt=5.
6. Reset mid-group:
   - Stimulus: two beats of 500, assert i_resetn=0 asynchronously, release, then single beat 7 last, shift=0.
   - Response: outputs 0 during reset, then out_data=7, out_cnt=1.

Source files
------------

// File: rtl/pe_acc_requant_pkg.sv
// rtl/pe_acc_requant_pkg.sv - shared widths, state encoding and saturation limits for pe_acc_requant
package pe_acc_requant_pkg;

    localparam int IW_DEF    = 18;
    localparam int ACC_W_DEF = 24;
    localparam int OW_DEF    = 8;
    localparam int SH_W_DEF  = 5;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/pe_acc_requant_requant_sat.sv
// rtl/pe_acc_requant_requant_sat.sv - combinational ReLU, round-half-up arithmetic shift and output saturation
import pe_acc_requant_pkg::*;

module requant_sat #(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OW    = OW_DEF,
    parameter int SH_W  = SH_W_DEF
) (
    input  logic signed [ACC_W-1:0] final_val,
    input  logic        [SH_W-1:0]  shift,
    input  logic                    relu,
    output logic signed [OW-1:0]    q_data,
    output logic                    q_sat
);

    localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'(sat_max(OW));
    localparam logic signed [ACC_W:0] Q_MIN = (ACC_W+1)'(sat_min(OW));

    logic signed [ACC_W:0] v;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] r;

    // One guard bit keeps the rounding add from overflowing at the accumulator max.
    always_comb begin
        v = (relu && final_val[ACC_W-1]) ? '0 : {final_val[ACC_W-1], final_val};
        rnd = '0;
        if (shift != '0)
            rnd = (ACC_W+1)'(1) << (shift - SH_W'(1));
        sum = v + rnd;
        r = sum >>> shift;
        q_sat = 1'b0;
        q_data = r[OW-1:0];
        if (r > Q_MAX) begin
            q_data = Q_MAX[OW-1:0];
            q_sat = 1'b1;
        end else if (r < Q_MIN) begin
            q_data = Q_MIN[OW-1:0];
            q_sat = 1'b1;
        end
    end

endmodule

// File: rtl/pe_acc_requant.sv
// rtl/pe_acc_requant.sv - saturating group accumulator with requantization and valid/ready handshake
import pe_acc_requant_pkg::*;

module pe_acc_requant #(
    parameter int IW    = IW_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int OW    = OW_DEF,
    parameter int SH_W  = SH_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IW-1:0]   in_data,
    input  logic                   in_last,
    input  logic        [SH_W-1:0] cfg_shift,
    input  logic                   cfg_relu,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [OW-1:0]   out_data,
    output logic                   out_sat,
    output logic        [CNT_W-1:0] out_cnt
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic        [CNT_W-1:0] cnt;
    logic                    sat_flag;

    logic signed [ACC_W:0]   in_ext;
    logic signed [ACC_W:0]   sum_w;
    logic                    add_ovf;
    logic signed [ACC_W-1:0] sum_sat;
    logic        [CNT_W-1:0] cnt_inc;
    logic signed [OW-1:0]    rq_data;
    logic                    rq_sat;

    assign in_ready = (state == ST_ACC);

    // Add in ACC_W+1 bits; disagreeing top bits mean the ACC_W result overflowed.
    always_comb begin
        in_ext  = {{(ACC_W+1-IW){in_data[IW-1]}}, in_data};
        sum_w   = {acc[ACC_W-1], acc} + in_ext;
        add_ovf = sum_w[ACC_W] ^ sum_w[ACC_W-1];
        if (add_ovf)
            sum_sat = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            sum_sat = sum_w[ACC_W-1:0];
        cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
    end

    requant_sat #(
        .ACC_W (ACC_W),
        .OW    (OW),
        .SH_W  (SH_W)
    ) u_requant_sat (
        .final_val (sum_sat),
        .shift     (cfg_shift),
        .relu      (cfg_relu),
        .q_data    (rq_data),
        .q_sat     (rq_sat)
    );

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state     <= ST_ACC;
            acc       <= '0;
            cnt       <= '0;
            sat_flag  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_cnt   <= '0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (in_valid) begin
                        if (in_last) begin
                            out_data  <= rq_data;
                            out_sat   <= sat_flag | add_ovf | rq_sat;
                            out_cnt   <= cnt_inc;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                            sat_flag  <= 1'b0;
                            state     <= ST_OUT;
                        end else begin
                            acc      <= sum_sat;
                            cnt      <= cnt_inc;
                            sat_flag <= sat_flag | add_ovf;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule
